payment_collector: RTL and testbench
====================================

Name: payment_collector

Overview:
- Sits directly upstream of the change dispenser.
- Takes the product price from the barcode stage, opens the acceptor, and accumulates inserted 2/10/20 EUR money until the price is covered or the purchase is cancelled.
- Then releases the product and hands the change (or full refund) amount to the dispenser over a valid/ready handshake.
- All amounts are in whole euros and always even.

Parameters:
- MAX_CREDIT, 30, highest credit the machine may hold (even, ≤ 30).
- TIMEOUT_CYCLES, 1000, inactivity limit in clock cycles; only used when PAYMENT_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears the block immediately.
- price_valid  input  1  one-cycle pulse: price is valid.
- price  input  5  product price in EUR.
- price_ready  output  1  high in IDLE only.
- price_error  output  1  one-cycle pulse: price rejected.
- coin2_in  input  1  one-cycle pulse per 2 EUR coin.
- note10_in  input  1  one-cycle pulse per 10 EUR note.
- note20_in  input  1  one-cycle pulse per 20 EUR note.
- cancel  input  1  level; user abort request.
- accept_enable  output  1  acceptor slot open; high in COLLECT only.
- reject_out  output  1  one-cycle pulse: the just-inserted item is returned unaccepted.
- credit  output  5  current accumulated credit, for display.
- product_release  output  1  one-cycle pulse: dispense product.
- change_valid  output  1  change_amount is valid.
- change_amount  output  5  EUR to return, even, 0..MAX_CREDIT.
- change_ready  input  1  dispenser accepts the amount.

Behaviour:
- Reset values: state IDLE; credit, change_amount and all pulse/status outputs are 0, except price_ready=1. Reset mid-operation discards credit and any pending handoff, with no release and no change.
- States: IDLE, COLLECT, VEND, HANDOFF.
- IDLE:
  - On price_valid with price even, nonzero and ≤ MAX_CREDIT: latch price, credit←0, go to COLLECT next cycle.
  - Otherwise, on price_valid: pulse price_error the next cycle and stay in IDLE.
  - Coin/note pulses: each pulse produces reject_out.
- COLLECT:
  - Insertion value: if several insert pulses arrive in the same cycle, accept only the highest (20 > 10 > 2); each other one produces reject_out in the following cycle.
  - Accepting value v: if credit+v ≤ MAX_CREDIT (compare in 6 bits), credit←credit+v; credit is visible one cycle after the pulse. Otherwise reject_out pulses and credit is unchanged.
  - When registered credit ≥ price: go to VEND; this takes priority over cancel in the same cycle.
  - When cancel=1 and credit < price: change_amount←credit, no release. If credit=0 go to IDLE, else go to HANDOFF.
- VEND (one cycle):
  - product_release=1 and change_amount←credit−price.
  - Next state: HANDOFF if change ≠ 0, else IDLE.
  - credit←0.
- HANDOFF:
  - change_valid=1 with change_amount held stable until a cycle where change_ready=1. Transfer occurs on that edge.
  - Next state IDLE, change_valid←0, credit←0.
  - change_ready while not valid is ignored.
- In VEND and HANDOFF: accept_enable=0 and every insert pulse produces reject_out; cancel is ignored.
- price_valid outside IDLE is ignored; no error pulse.
- Latency:
  - insert → credit: 1 cycle.
  - Exact payment: 2 cycles from the final insert pulse to the product_release pulse.

Optional Feature:
- Macro: PAYMENT_TIMEOUT_EN.
- Defined:
  - An inactivity counter runs in COLLECT; it resets on entry to COLLECT and on every accepted insertion.
  - When it reaches TIMEOUT_CYCLES, act exactly as cancel: refund credit via HANDOFF, or go to IDLE if credit=0.
  - The counter is idle and 0 outside COLLECT.
- Not defined: no counter is built; COLLECT is left only via payment or cancel.

Test Plan:
- Price 8, coin2 ×4 → credit 2,4,6,8; one product_release; no change_valid; return to IDLE.
- Price 12, note20 → product_release, then change_valid with change_amount=8. Hold change_ready=0 for 5 cycles: amount must stay stable. Then change_ready=1 → IDLE.
- Price 28, note20+note10 in the same cycle → credit 20, reject_out pulse; coin2 ×4 → release, change 0. Then price 7 → price_error, stay in IDLE.
- Price 14, note10, coin2, cancel → no release, change_amount=12 refund. An insert pulse during HANDOFF → reject_out.
- Credit 20, price 28, note20 → reject_out, credit stays 20. Assert reset=0 mid-COLLECT → all outputs at reset values, credit 0.
- With PAYMENT_TIMEOUT_EN and TIMEOUT_CYCLES=10: price 6, coin2, then idle 10 cycles → change_valid with amount 2. Without the macro → stay in COLLECT indefinitely.

Source files
------------

// File: rtl/payment_collector.sv
// -----------------------------------------------------------------------------
// payment_collector
//   Takes a price from the barcode stage and opens the money acceptor. It then
//   accumulates 2/10/20 EUR inserts until the price is covered or the user
//   cancels. After that it releases the product and passes the change (or the
//   full refund) to the change dispenser over a valid/ready handshake.
//   All amounts are whole, even euros.
//
// Optional feature (macro PAYMENT_TIMEOUT_EN):
//   When the macro is defined, an inactivity counter in COLLECT forces a
//   cancel after TIMEOUT_CYCLES cycles without an accepted insert.
//   When it is undefined, no counter is built.
//
// Handshake: change_valid rises with change_amount stable. The amount is
//   transferred on the first rising edge where change_valid && change_ready.
//   change_ready is ignored while change_valid is low.
//
// Ports:
//   clock, reset            rising-edge clock; asynchronous active-low reset
//   price_valid, price[4:0] price offer (one-cycle pulse), accepted in IDLE
//   price_ready             high in IDLE
//   price_error             one-cycle pulse after an invalid price
//   coin2_in/note10_in/note20_in  one-cycle insert pulses
//   cancel                  level, user abort
//   accept_enable           acceptor open (COLLECT)
//   reject_out              one-cycle pulse: an insert was returned
//   credit[4:0]             accumulated credit for the display
//   product_release         one-cycle pulse: dispense product
//   change_valid, change_amount[4:0], change_ready  change handoff
// -----------------------------------------------------------------------------
module payment_collector #(
   parameter int MAX_CREDIT     = 30,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       price_valid,
   input  logic [4:0] price,
   output logic       price_ready,
   output logic       price_error,
   input  logic       coin2_in,
   input  logic       note10_in,
   input  logic       note20_in,
   input  logic       cancel,
   output logic       accept_enable,
   output logic       reject_out,
   output logic [4:0] credit,
   output logic       product_release,
   output logic       change_valid,
   output logic [4:0] change_amount,
   input  logic       change_ready
);

   // Elaboration-time parameter sanity checks
   if ((MAX_CREDIT > 30) || (MAX_CREDIT < 2) || ((MAX_CREDIT % 2) != 0)) begin : g_bad_max
      $error("payment_collector: MAX_CREDIT must be even and in 2..30");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("payment_collector: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_HANDOFF = 2'd3
   } state_t;

   state_t     r_state, r_nxt_state;
   logic [4:0] r_price, r_credit, r_change_amount;
   logic       r_price_error, r_reject_out;

   logic [4:0] w_nxt_price, w_nxt_credit, w_nxt_change;
   logic       w_nxt_price_error, w_nxt_reject;

   logic       w_any_ins, w_multi_ins, w_fits, w_accept, w_price_ok, w_timeout;
   logic [5:0] w_ins_val, w_sum;
   logic [4:0] w_credit_after_ins;

   // Only the highest-valued simultaneous insert counts; the others are returned.
   assign w_any_ins   = coin2_in | note10_in | note20_in;
   assign w_multi_ins = (note20_in & (note10_in | coin2_in)) | (note10_in & coin2_in);
   assign w_ins_val   = note20_in ? 6'd20 : (note10_in ? 6'd10 : (coin2_in ? 6'd2 : 6'd0));

   // Sum in 6 bits so an overflow past 31 cannot wrap into an apparent fit
   assign w_sum    = {1'b0, r_credit} + w_ins_val;
   assign w_fits   = (w_sum <= 6'(MAX_CREDIT));
   assign w_accept = (r_state == S_COLLECT) && w_any_ins && w_fits;
   assign w_credit_after_ins = w_accept ? w_sum[4:0] : r_credit;

   assign w_price_ok = (price != 5'd0) && !price[0] && (price <= 5'(MAX_CREDIT));

`ifdef PAYMENT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_idle_cnt;

   assign w_timeout = (r_state == S_COLLECT) && (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES));

   // Cleared on entry to COLLECT (state still IDLE), on accepted inserts and
   // whenever COLLECT is being left, so it sits at 0 outside COLLECT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_idle_cnt <= '0;
      else if ((r_state != S_COLLECT) || (r_nxt_state != S_COLLECT) || w_accept)
         r_idle_cnt <= '0;
      else
         r_idle_cnt <= r_idle_cnt + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_price         <= 5'd0;
         r_credit        <= 5'd0;
         r_change_amount <= 5'd0;
         r_price_error   <= 1'b0;
         r_reject_out    <= 1'b0;
      end else begin
         r_state         <= r_nxt_state;
         r_price         <= w_nxt_price;
         r_credit        <= w_nxt_credit;
         r_change_amount <= w_nxt_change;
         r_price_error   <= w_nxt_price_error;
         r_reject_out    <= w_nxt_reject;
      end
   end

   // Next-state and next-register logic
   always_comb begin
      r_nxt_state       = r_state;
      w_nxt_price       = r_price;
      w_nxt_credit      = r_credit;
      w_nxt_change      = r_change_amount;
      w_nxt_price_error = 1'b0;
      w_nxt_reject      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_nxt_reject = w_any_ins;
            if (price_valid) begin
               if (w_price_ok) begin
                  w_nxt_price  = price;
                  w_nxt_credit = 5'd0;
                  r_nxt_state  = S_COLLECT;
               end else begin
                  w_nxt_price_error = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            w_nxt_credit = w_credit_after_ins;
            w_nxt_reject = w_multi_ins | (w_any_ins & ~w_fits);
            if (r_credit >= r_price) begin
               r_nxt_state = S_VEND;
            end else if (cancel || w_timeout) begin
               // Include an insert accepted in this same cycle so no money is lost
               w_nxt_change = w_credit_after_ins;
               r_nxt_state  = (w_credit_after_ins == 5'd0) ? S_IDLE : S_HANDOFF;
            end
         end
         S_VEND: begin
            w_nxt_reject = w_any_ins;
            w_nxt_change = r_credit - r_price;
            w_nxt_credit = 5'd0;
            r_nxt_state  = (r_credit != r_price) ? S_HANDOFF : S_IDLE;
         end
         S_HANDOFF: begin
            w_nxt_reject = w_any_ins;
            if (change_ready) begin
               w_nxt_change = 5'd0;
               w_nxt_credit = 5'd0;
               r_nxt_state  = S_IDLE;
            end
         end
         default: r_nxt_state = S_IDLE;
      endcase
   end

   assign price_ready     = (r_state == S_IDLE);
   assign accept_enable   = (r_state == S_COLLECT);
   assign product_release = (r_state == S_VEND);
   assign change_valid    = (r_state == S_HANDOFF);
   assign price_error     = r_price_error;
   assign reject_out      = r_reject_out;
   assign credit          = r_credit;
   assign change_amount   = r_change_amount;

endmodule

// File: tb/tb_payment_collector.sv
// -----------------------------------------------------------------------------
// tb_payment_collector
//   Directed bench for payment_collector. Inputs change 1 ns after a rising
//   edge, and outputs are checked at that same point, after the edge.
// -----------------------------------------------------------------------------
module tb_payment_collector;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       price_valid = 1'b0;
   logic [4:0] price = 5'd0;
   logic       price_ready, price_error;
   logic       coin2_in = 1'b0, note10_in = 1'b0, note20_in = 1'b0;
   logic       cancel = 1'b0;
   logic       accept_enable, reject_out;
   logic [4:0] credit;
   logic       product_release, change_valid;
   logic [4:0] change_amount;
   logic       change_ready = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   payment_collector #(
      .MAX_CREDIT     (30),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .price_valid     (price_valid),
      .price           (price),
      .price_ready     (price_ready),
      .price_error     (price_error),
      .coin2_in        (coin2_in),
      .note10_in       (note10_in),
      .note20_in       (note20_in),
      .cancel          (cancel),
      .accept_enable   (accept_enable),
      .reject_out      (reject_out),
      .credit          (credit),
      .product_release (product_release),
      .change_valid    (change_valid),
      .change_amount   (change_amount),
      .change_ready    (change_ready)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic offer_price(input logic [4:0] p);
      price_valid = 1'b1;
      price       = p;
      step();
      price_valid = 1'b0;
      price       = 5'd0;
   endtask

   task automatic insert(input logic c2, input logic n10, input logic n20);
      coin2_in  = c2;
      note10_in = n10;
      note20_in = n20;
      step();
      coin2_in  = 1'b0;
      note10_in = 1'b0;
      note20_in = 1'b0;
   endtask

   initial begin
      // ---------------- reset values ----------------
      step();
      step();
      check("rst_price_ready", price_ready, 1);
      check("rst_credit", credit, 0);
      check("rst_accept_enable", accept_enable, 0);
      check("rst_change_valid", change_valid, 0);
      check("rst_change_amount", change_amount, 0);
      check("rst_release", product_release, 0);
      check("rst_reject", reject_out, 0);
      check("rst_price_error", price_error, 0);
      reset = 1'b1;
      step();

      // ---------------- price 8, coin2 x4: exact payment ----------------
      offer_price(5'd8);
      check("t1_accept_enable", accept_enable, 1);
      check("t1_price_ready", price_ready, 0);
      check("t1_credit0", credit, 0);
      insert(1, 0, 0); check("t1_credit2", credit, 2);
      insert(1, 0, 0); check("t1_credit4", credit, 4);
      insert(1, 0, 0); check("t1_credit6", credit, 6);
      insert(1, 0, 0); check("t1_credit8", credit, 8);
      check("t1_no_release_yet", product_release, 0);
      step();
      check("t1_release", product_release, 1);
      check("t1_no_change_valid", change_valid, 0);
      step();
      check("t1_release_pulse_end", product_release, 0);
      check("t1_back_idle", price_ready, 1);
      check("t1_change_valid_idle", change_valid, 0);
      check("t1_credit_cleared", credit, 0);

      // ---------------- price 12, note20: change 8 with backpressure ----------------
      offer_price(5'd12);
      insert(0, 0, 1);
      check("t2_credit20", credit, 20);
      step();
      check("t2_release", product_release, 1);
      step();
      check("t2_change_valid", change_valid, 1);
      check("t2_change_amount", change_amount, 8);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_hold_valid", change_valid, 1);
         check("t2_hold_amount", change_amount, 8);
      end
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      check("t2_done_valid", change_valid, 0);
      check("t2_done_idle", price_ready, 1);

      // ---------------- price 28, note20+note10 together, then coins ----------------
      offer_price(5'd28);
      insert(0, 1, 1);
      check("t3_credit20", credit, 20);
      check("t3_reject_multi", reject_out, 1);
      insert(1, 0, 0);
      check("t3_credit22", credit, 22);
      check("t3_reject_clear", reject_out, 0);
      insert(1, 0, 0); check("t3_credit24", credit, 24);
      insert(1, 0, 0); check("t3_credit26", credit, 26);
      insert(1, 0, 0); check("t3_credit28", credit, 28);
      step();
      check("t3_release", product_release, 1);
      step();
      check("t3_idle", price_ready, 1);
      check("t3_no_change_valid", change_valid, 0);
      check("t3_change_zero", change_amount, 0);
      offer_price(5'd7);
      check("t3_price_error_odd", price_error, 1);
      check("t3_stay_idle", price_ready, 1);
      step();
      check("t3_price_error_pulse", price_error, 0);
      offer_price(5'd0);
      check("t3_price_error_zero", price_error, 1);
      step();

      // ---------------- price 14, note10, coin2, cancel: refund 12 ----------------
      offer_price(5'd14);
      insert(0, 1, 0); check("t4_credit10", credit, 10);
      insert(1, 0, 0); check("t4_credit12", credit, 12);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("t4_no_release", product_release, 0);
      check("t4_refund_valid", change_valid, 1);
      check("t4_refund_amount", change_amount, 12);
      insert(1, 0, 0);
      check("t4_reject_in_handoff", reject_out, 1);
      check("t4_still_valid", change_valid, 1);
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      check("t4_idle", price_ready, 1);
      check("t4_no_release_after", product_release, 0);

      // ---------------- overflow reject, then async reset mid-COLLECT ----------------
      offer_price(5'd28);
      insert(0, 0, 1); check("t5_credit20", credit, 20);
      insert(0, 0, 1);
      check("t5_overflow_reject", reject_out, 1);
      check("t5_credit_kept", credit, 20);
      check("t5_still_collect", accept_enable, 1);
      reset = 1'b0;
      #2;
      check("t5_rst_price_ready", price_ready, 1);
      check("t5_rst_credit", credit, 0);
      check("t5_rst_accept", accept_enable, 0);
      check("t5_rst_reject", reject_out, 0);
      check("t5_rst_change_valid", change_valid, 0);
      check("t5_rst_change_amount", change_amount, 0);
      check("t5_rst_release", product_release, 0);
      step();
      reset = 1'b1;
      step();
      check("t5_after_rst_idle", price_ready, 1);
      check("t5_after_rst_no_release", product_release, 0);

      // ---------------- price 6, coin2, then inactivity ----------------
      offer_price(5'd6);
      insert(1, 0, 0);
      check("t6_credit2", credit, 2);
`ifdef PAYMENT_TIMEOUT_EN
      begin
         int waited = 0;
         while (!change_valid && waited < 40) begin
            step();
            waited++;
         end
         check("t6_timeout_reached", {31'd0, change_valid}, 1);
         check("t6_timeout_amount", change_amount, 2);
         check("t6_timeout_cycles", waited, 11);
         change_ready = 1'b1;
         step();
         change_ready = 1'b0;
         check("t6_timeout_idle", price_ready, 1);
      end
`else
      // A price offer outside IDLE must be ignored without an error pulse
      offer_price(5'd7);
      check("t6_no_price_error", price_error, 0);
      for (int i = 0; i < 40; i++) step();
      check("t6_still_collect", accept_enable, 1);
      check("t6_no_change_valid", change_valid, 0);
      check("t6_credit_kept", credit, 2);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("t6_refund_amount", change_amount, 2);
      check("t6_refund_valid", change_valid, 1);
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      check("t6_idle", price_ready, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
